register_file: RTL and testbench

- 32-entry general-purpose register file feeding the execution stage of the single-cycle processor.
- Two asynchronous read ports (rs, rt) drive the ALU A/B operand inputs. One synchronous write port receives the write-back result (ALU result or memory load data).
- Register 0 is hardwired to zero.
- A synchronous active-low reset clears every register so that simulation and FPGA start-up are deterministic.

---
 rtl/register_file_pkg.sv | 30 +++
 rtl/register_file.sv | 79 +++++++
 tb/tb_register_file.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// register_file_pkg
// ----------------------------------------------------------------------------
// Processor-wide constants that the register file, the control path and the
// bench all share: datapath and register-index widths, the named register
// indices, and the ALU control encodings consumed by the execute stage.
// Revision: 1.0  initial release
// ============================================================================
package register_file_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_RA   = 5'd31;

  // ALU control encodings, driven by the ALU decoder downstream.
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// register_file
// ----------------------------------------------------------------------------
// 32-entry general-purpose register file for the single-cycle datapath.
// Two combinational read ports feed the ALU operands; one synchronous write
// port takes the write-back result. Register 0 reads as zero and is not
// backed by storage.
//
// Ports:
//   i_clk      in   1           clock, all updates on the rising edge
//   i_rst_n    in   1           synchronous active-low reset, clears all regs
//   i_rs_addr  in   ADDR_WIDTH  read port A index
//   i_rt_addr  in   ADDR_WIDTH  read port B index
//   i_wr_en    in   1           write enable
//   i_wr_addr  in   ADDR_WIDTH  write index
//   i_wr_data  in   DATA_WIDTH  write-back data
//   o_rs_data  out  DATA_WIDTH  contents of register i_rs_addr (ALU A)
//   o_rt_data  out  DATA_WIDTH  contents of register i_rt_addr (ALU B/store)
//
// Revision: 1.0  initial release
// ============================================================================
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::REG_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [ADDR_WIDTH-1:0] i_rt_addr,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_rs_data,
  output logic [DATA_WIDTH-1:0] o_rt_data
);

  // Derived from the address width so every index is in range.
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Entry 0 has no storage; the array starts at index 1.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

  // Reset wins over a write presented in the same cycle. Writes to index 0
  // never match a storage entry, so they fall away without extra logic.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (i_wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_wr_addr == ADDR_WIDTH'(i)) begin
          regs[i] <= i_wr_data;
        end
      end
    end
  end

  // Read muxes. No write-to-read bypass: the write data is a combinational
  // function of these outputs in the single-cycle datapath, so a bypass
  // would close a combinational loop. Index 0 falls through to zero.
  always_comb begin
    o_rs_data = '0;
    o_rt_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (i_rs_addr == ADDR_WIDTH'(i)) begin
        o_rs_data = regs[i];
      end
      if (i_rt_addr == ADDR_WIDTH'(i)) begin
        o_rt_data = regs[i];
      end
    end
  end

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// tb_register_file
// ----------------------------------------------------------------------------
// Self-checking bench for register_file. Expected read values are queued as
// each read is set up and popped when the outputs are sampled.
// Revision: 1.0  initial release
// ============================================================================
module tb_register_file;
  import register_file_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;

  int vectors;
  int miscompares;

  // Reference contents, maintained from the documented write/reset rules.
  logic [DW-1:0] mdl [0:31];

  typedef struct {
    string         tag;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
  } exp_t;

  exp_t sb [$];

  register_file #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rs_addr (rs_addr),
    .i_rt_addr (rt_addr),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_rs_data (rs_data),
    .o_rt_data (rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present read addresses, queue the expectation, then sample and compare.
  task automatic read_pair(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                           input string tag);
    exp_t e;
    rs_addr = ra;
    rt_addr = rb;
    sb.push_back('{tag: tag, rs: ea, rt: eb});
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_rs"}, rs_data, e.rs);
      check({e.tag, "_rt"}, rt_data, e.rt);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a != 5'd0) mdl[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state: every index reads zero.
    @(negedge clk);
    for (int i = 0; i < 32; i += 2) begin
      read_pair(AW'(i), AW'(i + 1), 32'h0, 32'h0, "por");
    end

    // Reset clear after a real write.
    do_write(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    read_pair(5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "pre_rst_r5");
    do_reset();
    @(negedge clk);
    read_pair(5'd5, 5'd5, 32'h0, 32'h0, "rst_r5");
    for (int i = 0; i < 32; i++) begin
      read_pair(AW'(i), AW'(31 - i), 32'h0, 32'h0, "rst_all");
    end

    // Basic write/read, two ports simultaneously.
    do_write(5'd7, 32'h12345678);
    do_write(REG_RA, 32'hFFFFFFFF);
    @(negedge clk);
    read_pair(5'd7, REG_RA, 32'h12345678, 32'hFFFFFFFF, "basic");
    read_pair(REG_RA, 5'd7, 32'hFFFFFFFF, 32'h12345678, "basic_swap");

    // Zero register ignores writes.
    do_write(REG_ZERO, 32'hA5A5A5A5);
    @(negedge clk);
    read_pair(5'd0, 5'd0, 32'h0, 32'h0, "zero_reg");

    // Enable gating, including unknown data.
    do_write(5'd3, 32'h11111111);
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd3; wr_data = 32'h22222222;
    @(posedge clk);
    #1;
    @(negedge clk);
    read_pair(5'd3, 5'd3, 32'h11111111, 32'h11111111, "wen_off");
    wr_data = 'x;
    @(posedge clk);
    #1;
    @(negedge clk);
    read_pair(5'd3, 5'd3, 32'h11111111, 32'h11111111, "wen_off_x");
    wr_data = '0;

    // Read-during-write returns the old value until the edge.
    do_write(5'd9, 32'h00000001);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000002;
    read_pair(5'd9, 5'd9, 32'h00000001, 32'h00000001, "rdw_before");
    #2;
    read_pair(5'd9, 5'd9, 32'h00000001, 32'h00000001, "rdw_late");
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    mdl[9] = 32'h00000002;
    read_pair(5'd9, 5'd9, 32'h00000002, 32'h00000002, "rdw_after");

    // Reset has priority over a simultaneous write.
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    read_pair(5'd4, 5'd9, 32'h0, 32'h0, "rst_prio");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    mdl[4] = 32'hCAFEF00D;
    read_pair(5'd4, 5'd7, 32'hCAFEF00D, 32'h0, "rst_then_wr");

    // Random writes across all indices, then sweep both ports.
    for (int k = 0; k < 24; k++) begin
      do_write(AW'($urandom_range(0, 31)), $urandom);
    end
    do_write(REG_SP, 32'h7FFF_FFF0);
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      read_pair(AW'(a), AW'(31 - a), mdl[a], mdl[31 - a], "sweep");
    end
    read_pair(REG_SP, REG_ZERO, 32'h7FFF_FFF0, 32'h0, "sp");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file
`default_nettype wire
